// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding, run-status
// codes and the exit-status priority encoder.
package cpu_run_ctrl_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [STATUS_W-1:0] ST_NONE    = 2'b00;
  localparam logic [STATUS_W-1:0] ST_HALT    = 2'b01;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b10;
  localparam logic [STATUS_W-1:0] ST_ABORT   = 2'b11;

  // Resolve simultaneous run-exit causes: abort > halt > timeout.
  function automatic logic [STATUS_W-1:0] exit_status(input logic abort_i,
                                                      input logic halt_i,
                                                      input logic timeout_i);
    if (abort_i)        return ST_ABORT;
    else if (halt_i)    return ST_HALT;
    else if (timeout_i) return ST_TIMEOUT;
    else                return ST_NONE;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_pc_stall.sv
// pc_stall_detector: flags a program halt when the CPU PC stays unchanged for
// HALT_REPEAT consecutive valid samples (a PC self-loop).
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   clr           synchronous clear; held high whenever the CPU is not running
//   pc, pc_valid  observed program counter and its qualifier
//   halt          combinational: this cycle's sample completes the repeat run
module pc_stall_detector #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned HALT_REPEAT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic [PC_W-1:0] pc,
  input  logic            pc_valid,
  output logic            halt
);

  localparam int unsigned SAME_W = $clog2(HALT_REPEAT) + 1;
  localparam logic [SAME_W-1:0] SAME_TARGET = SAME_W'(HALT_REPEAT - 1);

  logic [PC_W-1:0]   last_pc_q,  last_pc_d;
  logic              last_vld_q, last_vld_d;
  logic [SAME_W-1:0] same_cnt_q, same_cnt_d;

  // Repeat counting; last_vld keeps the first sample after a clear from
  // matching the cleared last_pc (a CPU restarting at PC 0 is not a halt).
  always_comb begin
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    same_cnt_d = same_cnt_q;
    if (clr) begin
      last_pc_d  = '0;
      last_vld_d = 1'b0;
      same_cnt_d = '0;
    end else if (pc_valid) begin
      if (last_vld_q && (pc == last_pc_q)) begin
        if (same_cnt_q < SAME_TARGET) same_cnt_d = same_cnt_q + SAME_W'(1);
      end else begin
        same_cnt_d = '0;
        last_pc_d  = pc;
        last_vld_d = 1'b1;
      end
    end
  end

  assign halt = !clr && (same_cnt_d >= SAME_TARGET);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      same_cnt_q <= '0;
    end else begin
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
      same_cnt_q <= same_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: drives the MIPS CPU active-low reset through a programmable
// hold, counts run cycles and ends the run on halt, timeout or abort.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   start, abort       1-cycle control pulses
//   pc, pc_valid       observed CPU program counter
//   cpu_rst_n          active-low CPU reset (registered)
//   running, done      run / finished flags (registered)
//   status             exit cause, valid while done=1
//   cycle_cnt          saturating RUN-cycle count, frozen in DONE
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 2,
  parameter int unsigned MAX_CYCLES      = 8,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned HALT_REPEAT     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PC_W-1:0]     pc,
  input  logic                pc_valid,
  output logic                cpu_rst_n,
  output logic                running,
  output logic                done,
  output logic [STATUS_W-1:0] status,
  output logic [CNT_W-1:0]    cycle_cnt
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                cpu_rst_n_q;
  logic                running_q;
  logic                done_q;
  logic [STATUS_W-1:0] status_q;
  logic [CNT_W-1:0]    cycle_cnt_q;

  logic [CNT_W-1:0]    cycle_cnt_d;
  logic                halt_c;
  logic                timeout_c;
  logic                stall_clr_c;

  // Stall detector only observes the PC while the CPU is out of reset.
  assign stall_clr_c = (state_q != RUN);

  pc_stall_detector #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_stall (
    .clock    (clock),
    .reset    (reset),
    .clr      (stall_clr_c),
    .pc       (pc),
    .pc_valid (pc_valid),
    .halt     (halt_c)
  );

  // Saturating increment; timeout compares the post-increment count.
  assign cycle_cnt_d = (cycle_cnt_q == {CNT_W{1'b1}}) ? cycle_cnt_q
                                                      : cycle_cnt_q + CNT_W'(1);
  assign timeout_c   = (MAX_CYCLES != 0) && (64'(cycle_cnt_d) == 64'(MAX_CYCLES));

  // Run sequencer with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_NONE;
      cycle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (abort) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            status_q    <= ST_ABORT;
            cycle_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= RUN;
            cpu_rst_n_q <= 1'b1;
            running_q   <= 1'b1;
            cycle_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          if (abort || halt_c || timeout_c) begin
            state_q     <= DONE;
            cpu_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
            status_q    <= exit_status(abort, halt_c, timeout_c);
          end
        end
        DONE: begin
          // start outranks a coincident abort; abort alone is ignored here.
          if (start) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
            status_q    <= ST_NONE;
            cycle_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign running   = running_q;
  assign done      = done_q;
  assign status    = status_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule
